e203_exu_longp_rob: RTL and testbench
=====================================

# e203_exu_longp_rob

Small per-itag result buffer between the long-pipe units (LSU, NICE) and the long-pipe write-back arbiter. Results arrive out of order, tagged with their OITF itag. The block parks each result in the slot indexed by that itag, then releases slots strictly in OITF retirement order (`oitf_ret_ptr`). A long-pipe unit that finishes early is freed immediately instead of stalling until its itag reaches the OITF head.

## Interface

Parameters:
- `ITAG_W`, default 1: itag width; the buffer has DEPTH = 2^ITAG_W slots, matching OITF depth.
- `XLEN`, default 32: result data width.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `lsu_i_valid`  in  1  LSU result valid.
- `lsu_i_ready`  out  1  LSU result accepted.
- `lsu_i_itag`  in  ITAG_W  itag of the LSU result.
- `lsu_i_wdat`  in  XLEN  LSU result data.
- `lsu_i_err`  in  1  LSU error flag.
- `nice_i_valid`  in  1  NICE result valid.
- `nice_i_ready`  out  1  NICE result accepted.
- `nice_i_itag`  in  ITAG_W  itag of the NICE result.
- `nice_i_wdat`  in  XLEN  NICE result data.
- `nice_i_err`  in  1  NICE error flag.
- `oitf_empty`  in  1  OITF holds no entry.
- `oitf_ret_ptr`  in  ITAG_W  itag at the OITF head.
- `flush`  in  1  pipeline flush; discard all buffered results.
- `wbck_o_valid`  out  1  in-order result valid toward the write-back arbiter.
- `wbck_o_ready`  in  1  write-back arbiter accepts.
- `wbck_o_itag`  out  ITAG_W  equals `oitf_ret_ptr`.
- `wbck_o_wdat`  out  XLEN  buffered data.
- `wbck_o_err`  out  1  buffered error flag.
- `wbck_o_src`  out  1  source of the result: 0 = LSU, 1 = NICE.
- `occ_cnt`  out  ITAG_W+1  number of occupied slots.

## Operation

Per-slot state:
- Each slot i holds `vld[i]`, `wdat[i]`, `err[i]`, `src[i]`.
- Every slot has two states: EMPTY (`vld`=0) and FULL (`vld`=1).
- EMPTY -> FULL on an input accept targeting that slot.
- FULL -> EMPTY on an output handshake while `oitf_ret_ptr`=i, or on `flush`.
- Data fields are written only on accept. Their reset value is don't-care; only `vld` is reset.

Input acceptance:
- `lsu_i_ready` = ~`flush` & ~`vld[lsu_i_itag]`.
- `nice_i_ready` = ~`flush` & ~`vld[nice_i_itag]` & ~(`lsu_i_valid` & `lsu_i_itag`==`nice_i_itag`).
- Same-itag collision: LSU wins and NICE waits. Different itags: both are accepted in the same cycle.
- A source must hold valid and payload stable while valid & ~ready.

Output:
- `wbck_o_valid` = ~`oitf_empty` & ~`flush` & `vld[oitf_ret_ptr]`.
- `wbck_o_wdat`, `wbck_o_err` and `wbck_o_src` come from slot `oitf_ret_ptr`.
- An output handshake (valid & ready) clears the slot at the next edge.
- Output is driven from registers only; there is no input-to-output bypass.

Occupancy counter:
- `occ_cnt` = `occ_cnt` + (number of accepts) − (1 if output handshake).
- The counter ranges over 0..DEPTH and never wraps.
- Mismatch between `occ_cnt` and popcount(`vld`) is an assertion failure.

Flush:
- Clears all `vld` bits and `occ_cnt` at the next edge.
- While `flush`=1, both input readies and `wbck_o_valid` are forced to 0.
- Flush overrides every simultaneous accept and drain.

## Timing

- Reset (`rst_n`=0 at an edge): all `vld`=0, `occ_cnt`=0.
- Outputs after reset: `wbck_o_valid`=0; `lsu_i_ready`=`nice_i_ready`=1 unless `flush` is asserted.
- Latency: a result accepted at edge N can be presented on `wbck_o_valid` from cycle N+1 onward, provided its itag is at the OITF head.
- Full slot: an input targeting an occupied slot sees ready=0 until the cycle after that slot drains.
- A slot drained at edge N can be re-accepted at edge N+1, never at edge N itself.
- Simultaneous drain of slot A and accept into slot B: both take effect and `occ_cnt` is unchanged.
- Two accepts with no drain: `occ_cnt` += 2. Two accepts plus a drain: `occ_cnt` += 1.
- `oitf_empty`=1 masks `wbck_o_valid` but does not clear slot contents.
- `oitf_ret_ptr` wraps modulo DEPTH with the OITF; the block needs no wrap logic beyond indexing.
- Reset asserted mid-operation: all buffered results are lost at that edge, identical to a flush.

## Test plan

- Out of order: ret_ptr=0. NICE (itag1, 0xBEEF) is accepted at edge 1, then LSU (itag0, 0x1234) at edge 3. Output shows 0x1234 with src=0 first, and 0xBEEF with src=1 only after ret_ptr advances to 1. `occ_cnt` goes 1 -> 2 -> 1 -> 0.
- Collision: LSU and NICE are both valid with itag0 in the same cycle. LSU is accepted and `nice_i_ready`=0. The next cycle `lsu_i_ready` for itag0 is 0 because the slot is full. NICE stays stalled until slot0 drains.
- Back-pressure: slot0 full, `wbck_o_ready`=0 for 5 cycles. `wbck_o_valid` holds 1 with stable data, and `occ_cnt` stays at 1.
- Drain plus fill: slot0 drains while LSU itag1 is accepted in the same cycle. `occ_cnt` is unchanged. Slot0 re-accepts a new result one cycle later.
- Flush: with both slots full, assert `flush` for 1 cycle. Readies and `wbck_o_valid` are 0 during flush. After flush, `occ_cnt`=0, both readies are 1 and `wbck_o_valid`=0.
- Reset and err: an error result (`lsu_i_err`=1) is held in a slot and `rst_n`=0 is asserted. After reset the slot is empty. A new err result later appears with `wbck_o_err`=1.

Source files
------------

// File: rtl/e203_exu_longp_rob.sv
// e203_exu_longp_rob: per-itag result buffer releasing long-pipe results in OITF retirement order
module e203_exu_longp_rob #(
  parameter int ITAG_W = 1,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_i_valid,
  output logic              lsu_i_ready,
  input  logic [ITAG_W-1:0] lsu_i_itag,
  input  logic [XLEN-1:0]   lsu_i_wdat,
  input  logic              lsu_i_err,
  input  logic              nice_i_valid,
  output logic              nice_i_ready,
  input  logic [ITAG_W-1:0] nice_i_itag,
  input  logic [XLEN-1:0]   nice_i_wdat,
  input  logic              nice_i_err,
  input  logic              oitf_empty,
  input  logic [ITAG_W-1:0] oitf_ret_ptr,
  input  logic              flush,
  output logic              wbck_o_valid,
  input  logic              wbck_o_ready,
  output logic [ITAG_W-1:0] wbck_o_itag,
  output logic [XLEN-1:0]   wbck_o_wdat,
  output logic              wbck_o_err,
  output logic              wbck_o_src,
  output logic [ITAG_W:0]   occ_cnt
);
  localparam int DEPTH = 1 << ITAG_W;
  localparam int CW    = ITAG_W + 1;
  logic [DEPTH-1:0] vld, vld_nxt, err, src;
  logic [XLEN-1:0]  wdat [DEPTH];
  logic             lsu_acc, nice_acc, wb_hsk;
  assign lsu_i_ready  = ~flush & ~vld[lsu_i_itag];
  assign nice_i_ready = ~flush & ~vld[nice_i_itag] & ~(lsu_i_valid & (lsu_i_itag == nice_i_itag));
  assign lsu_acc      = lsu_i_valid & lsu_i_ready;
  assign nice_acc     = nice_i_valid & nice_i_ready;
  assign wbck_o_valid = ~oitf_empty & ~flush & vld[oitf_ret_ptr];
  assign wb_hsk       = wbck_o_valid & wbck_o_ready;
  assign wbck_o_itag  = oitf_ret_ptr;
  assign wbck_o_wdat  = wdat[oitf_ret_ptr];
  assign wbck_o_err   = err[oitf_ret_ptr];
  assign wbck_o_src   = src[oitf_ret_ptr];
  // accepts only target empty slots and drains only full ones, so the updates never collide
  always_comb begin
    vld_nxt = vld;
    if (wb_hsk) vld_nxt[oitf_ret_ptr] = 1'b0;
    if (lsu_acc) vld_nxt[lsu_i_itag] = 1'b1;
    if (nice_acc) vld_nxt[nice_i_itag] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      vld     <= '0;
      occ_cnt <= '0;
    end else begin
      vld     <= vld_nxt;
      occ_cnt <= occ_cnt + CW'(lsu_acc) + CW'(nice_acc) - CW'(wb_hsk);
    end
  end
  always_ff @(posedge clk) begin
    if (lsu_acc) begin
      wdat[lsu_i_itag] <= lsu_i_wdat;
      err[lsu_i_itag]  <= lsu_i_err;
      src[lsu_i_itag]  <= 1'b0;
    end
    if (nice_acc) begin
      wdat[nice_i_itag] <= nice_i_wdat;
      err[nice_i_itag]  <= nice_i_err;
      src[nice_i_itag]  <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n) assert (32'(occ_cnt) == $countones(vld));
  end
endmodule

// File: tb/tb_e203_exu_longp_rob.sv
// tb_e203_exu_longp_rob: directed test-plan scenarios plus random traffic against a slot-array model
module tb_e203_exu_longp_rob;
  localparam int IW = 1;
  localparam int D  = 2;
  logic clk = 0, rst_n = 0;
  logic lv = 0, le = 0, nv = 0, ne = 0, oe = 1, fl = 0, wr = 0;
  logic [IW-1:0] lt = 0, nt = 0, rp = 0;
  logic [31:0] ld = 0, nd = 0;
  logic lr, nr, wv, werr, wsrc;
  logic [IW-1:0] witag;
  logic [31:0] wdat;
  logic [IW:0] occ;
  int n_chk = 0, n_err = 0;
  logic chk_en = 0, stall_l = 0, stall_n = 0;
  logic m_vld [D] = '{default: 0};
  logic [31:0] m_dat [D];
  logic m_err [D], m_src [D];

  e203_exu_longp_rob #(.ITAG_W(IW), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_i_valid(lv), .lsu_i_ready(lr), .lsu_i_itag(lt), .lsu_i_wdat(ld), .lsu_i_err(le),
    .nice_i_valid(nv), .nice_i_ready(nr), .nice_i_itag(nt), .nice_i_wdat(nd), .nice_i_err(ne),
    .oitf_empty(oe), .oitf_ret_ptr(rp), .flush(fl),
    .wbck_o_valid(wv), .wbck_o_ready(wr), .wbck_o_itag(witag), .wbck_o_wdat(wdat),
    .wbck_o_err(werr), .wbck_o_src(wsrc), .occ_cnt(occ)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // model: slot array, expected outputs derived from its contents, then the edge's effect applied
  always @(negedge clk) begin
    logic elr, enr, ewv;
    int cnt;
    if (chk_en) begin
      elr = !fl && !m_vld[lt];
      enr = !fl && !m_vld[nt] && !(lv && lt == nt);
      ewv = !oe && !fl && m_vld[rp];
      cnt = 0;
      for (int i = 0; i < D; i++) cnt += int'(m_vld[i]);
      chk("lsu_ready", 64'(lr), 64'(elr));
      chk("nice_ready", 64'(nr), 64'(enr));
      chk("wbck_valid", 64'(wv), 64'(ewv));
      chk("wbck_itag", 64'(witag), 64'(rp));
      chk("occ_cnt", 64'(occ), 64'(cnt));
      if (ewv) begin
        chk("wbck_wdat", 64'(wdat), 64'(m_dat[rp]));
        chk("wbck_err", 64'(werr), 64'(m_err[rp]));
        chk("wbck_src", 64'(wsrc), 64'(m_src[rp]));
      end
      stall_l = lv && !elr;
      stall_n = nv && !enr;
      if (!rst_n || fl) begin
        for (int i = 0; i < D; i++) m_vld[i] = 0;
      end else begin
        if (ewv && wr) m_vld[rp] = 0;
        if (lv && elr) begin
          m_vld[lt] = 1; m_dat[lt] = ld; m_err[lt] = le; m_src[lt] = 0;
        end
        if (nv && enr) begin
          m_vld[nt] = 1; m_dat[nt] = nd; m_err[nt] = ne; m_src[nt] = 1;
        end
      end
    end
  end

  initial begin
    cyc();
    chk_en = 1;
    cyc();
    // out of order: NICE itag1 first, LSU itag0 later, released in itag order
    rst_n = 1; oe = 0; rp = 0; wr = 1;
    nv = 1; nt = 1; nd = 32'hBEEF;
    cyc(); nv = 0; #1;
    chk("ooo_occ1", 64'(occ), 1);
    chk("ooo_wv0", 64'(wv), 0);
    lv = 1; lt = 0; ld = 32'h1234;
    cyc(); lv = 0; wr = 0; #1;
    chk("ooo_occ2", 64'(occ), 2);
    chk("ooo_wv1", 64'(wv), 1);
    chk("ooo_dat0", 64'(wdat), 64'h1234);
    chk("ooo_src0", 64'(wsrc), 0);
    wr = 1;
    cyc(); wr = 0; #1;
    chk("ooo_occ1b", 64'(occ), 1);
    chk("ooo_wv_head0", 64'(wv), 0);
    rp = 1; #1;
    chk("ooo_dat1", 64'(wdat), 64'hBEEF);
    chk("ooo_src1", 64'(wsrc), 1);
    wr = 1;
    cyc(); wr = 0; #1;
    chk("ooo_occ0", 64'(occ), 0);
    // collision on itag0, then back-pressure
    rp = 0;
    lv = 1; lt = 0; ld = 32'hAAAA;
    nv = 1; nt = 0; nd = 32'h5555; ne = 0; #1;
    chk("col_lr", 64'(lr), 1);
    chk("col_nr", 64'(nr), 0);
    cyc(); lv = 0; #1;
    chk("col_lr_full", 64'(lr), 0);
    chk("col_nr_full", 64'(nr), 0);
    for (int k = 0; k < 5; k++) begin
      cyc(); #1;
      chk("bp_wv", 64'(wv), 1);
      chk("bp_dat", 64'(wdat), 64'hAAAA);
      chk("bp_occ", 64'(occ), 1);
      chk("bp_nr", 64'(nr), 0);
    end
    wr = 1;
    cyc(); wr = 0; #1;
    chk("col_drain_occ", 64'(occ), 0);
    chk("col_nr_free", 64'(nr), 1);
    cyc(); nv = 0; #1;
    chk("col_nice_occ", 64'(occ), 1);
    chk("col_nice_dat", 64'(wdat), 64'h5555);
    chk("col_nice_src", 64'(wsrc), 1);
    // drain slot0 while filling slot1, then refill slot0
    wr = 1; lv = 1; lt = 1; ld = 32'h1111;
    cyc(); wr = 0; lt = 0; ld = 32'h2222; #1;
    chk("df_occ", 64'(occ), 1);
    chk("df_lr0", 64'(lr), 1);
    cyc(); lv = 0; #1;
    chk("df_occ2", 64'(occ), 2);
    chk("df_dat", 64'(wdat), 64'h2222);
    // flush with both slots full
    fl = 1; #1;
    chk("fl_lr", 64'(lr), 0);
    chk("fl_nr", 64'(nr), 0);
    chk("fl_wv", 64'(wv), 0);
    cyc(); fl = 0; #1;
    chk("fl_occ", 64'(occ), 0);
    chk("fl_lr1", 64'(lr), 1);
    chk("fl_nr1", 64'(nr), 1);
    chk("fl_wv0", 64'(wv), 0);
    // reset mid-operation drops an error result; a later error result is visible
    lv = 1; lt = 0; ld = 32'hE0; le = 1;
    cyc(); lv = 0; #1;
    chk("rst_err_pre", 64'(werr), 1);
    rst_n = 0;
    cyc(); rst_n = 1; #1;
    chk("rst_occ", 64'(occ), 0);
    chk("rst_wv", 64'(wv), 0);
    lv = 1; lt = 1; ld = 32'hE1; le = 1; rp = 1;
    cyc(); lv = 0; le = 0; #1;
    chk("err_wv", 64'(wv), 1);
    chk("err_flag", 64'(werr), 1);
    chk("err_dat", 64'(wdat), 64'hE1);
    // random traffic, sources hold while stalled
    for (int k = 0; k < 4000; k++) begin
      cyc();
      rst_n = ($urandom_range(99) != 0);
      fl = ($urandom_range(29) == 0);
      if (!stall_l) begin
        lv = 1'($urandom_range(1)); lt = IW'($urandom); ld = $urandom; le = 1'($urandom_range(1));
      end
      if (!stall_n) begin
        nv = 1'($urandom_range(1)); nt = IW'($urandom); nd = $urandom; ne = 1'($urandom_range(1));
      end
      oe = ($urandom_range(7) == 0);
      rp = IW'($urandom);
      wr = ($urandom_range(3) != 0);
    end
    cyc();
    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
